axis_forwarder: RTL and testbench

// - Reader-side master of the packet filter forwarder interface: when the filter bank raises ready_for_forwarder, it drains the accepted packet.
// - Reads the packet word-by-word over forwarder_rd_addr/rd_en/rd_data and emits it as an AXI-Stream packet.
// - Pulses forwarder_done to hand the buffer back. Sits between the parallel filter bank and the egress AXIS fabric.

---
 rtl/axis_forwarder_if.sv | 14 +
 rtl/axis_forwarder.sv | 165 ++++++++++++++++
 tb/tb_axis_forwarder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_forwarder_if.sv
// AXI-Stream egress bundle used by axis_forwarder.
//   master : tdata/tvalid/tlast out, tready in  (the forwarder side)
//   slave  : the egress fabric side
interface axis_forwarder_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_forwarder.sv
// axis_forwarder: reader-side master of the packet filter forwarder port.
// When the filter bank raises ready_for_forwarder, the latched length is
// drained word by word over the forwarder read port (1-cycle read latency)
// through a 2-entry skid FIFO onto an AXI-Stream master, then the buffer is
// released with a one-cycle forwarder_done pulse followed by a 2-cycle hold.
//
// Ports
//   axi_aclk, resetn        clock, asynchronous active-low reset
//   ready_for_forwarder     bank has an accepted packet
//   len_to_forwarder        packet length in words (saturated to 2^W)
//   forwarder_rd_addr/en    word read request
//   forwarder_rd_data       read data, valid the cycle after rd_en
//   forwarder_done          buffer release pulse
//   m_axis                  AXI-Stream master (axis_forwarder_if.master)
//   pkt_count, empty_count  only with FWD_PKT_COUNT_EN defined
//
// Optional feature macro: FWD_PKT_COUNT_EN (packet / empty-packet counters).
// PLEN_WIDTH must equal SNOOP_FWD_ADDR_WIDTH+1.
// resetn is expected to be released synchronously to axi_aclk upstream.
module axis_forwarder #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH           = 64,
  parameter int PLEN_WIDTH           = 10
) (
  input  logic                            axi_aclk,
  input  logic                            resetn,
  input  logic                            ready_for_forwarder,
  input  logic [PLEN_WIDTH-1:0]           len_to_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                            forwarder_rd_en,
  input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
  output logic                            forwarder_done,
  axis_forwarder_if.master                m_axis
`ifdef FWD_PKT_COUNT_EN
  ,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     empty_count
`endif
);

  localparam logic [PLEN_WIDTH-1:0] ONE     = {{(PLEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PLEN_WIDTH-1:0] MAX_LEN = ONE << SNOOP_FWD_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [PLEN_WIDTH-1:0] len_q, len_d;
  logic [PLEN_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PLEN_WIDTH-1:0] beat_q, beat_d;
  logic                  hold_q, hold_d;

  // Skid FIFO: two entries, 1-bit pointers, 2-bit occupancy.
  logic [1:0][DATA_WIDTH-1:0] fifo_q;
  logic                       wr_q, rd_q;
  logic [1:0]                 cnt_q;
  logic                       infl_q;   // read issued last cycle, data arrives now

  logic                  tvalid, pop, tlast, rd_en;
  logic [1:0]            occ;
  logic [PLEN_WIDTH-1:0] len_sat;

  assign tvalid  = (cnt_q != 2'd0);
  assign pop     = tvalid & m_axis.tready;
  assign tlast   = tvalid & (beat_q == len_q - ONE);
  assign len_sat = (len_to_forwarder > MAX_LEN) ? MAX_LEN : len_to_forwarder;

  // Occupancy counts the word leaving this cycle as already gone; otherwise
  // the two-slot budget would stall every other cycle and tready=1 could not
  // sustain one beat per clock. Buffered + in flight still never exceeds 2.
  assign occ   = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign rd_en = (state_q == S_STREAM) && (occ < 2'd2) && (rd_ptr_q < len_q);

  assign forwarder_rd_en   = rd_en;
  assign forwarder_rd_addr = rd_ptr_q[SNOOP_FWD_ADDR_WIDTH-1:0];
  assign forwarder_done    = (state_q == S_DONE);
  assign m_axis.tdata      = fifo_q[rd_q];
  assign m_axis.tvalid     = tvalid;
  assign m_axis.tlast      = tlast;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    hold_d   = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (ready_for_forwarder) begin
          len_d    = len_sat;
          rd_ptr_d = '0;
          beat_d   = '0;
          state_d  = (len_sat == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_en) rd_ptr_d = rd_ptr_q + ONE;
        if (pop)   beat_d   = beat_q + ONE;
        if (pop && tlast) state_d = S_DONE;
      end
      S_DONE: begin
        hold_d  = 1'b0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Two cycles deaf to ready so the bank's arbiter can reselect.
        if (hold_q) state_d = S_IDLE;
        else        hold_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge axi_aclk or negedge resetn) begin
    if (!resetn) begin
      fifo_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= rd_en;
      if (infl_q) begin
        fifo_q[wr_q] <= forwarder_rd_data;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

`ifdef FWD_PKT_COUNT_EN
  logic [31:0] pkt_count_q, empty_count_q;

  always_ff @(posedge axi_aclk or negedge resetn) begin
    if (!resetn) begin
      pkt_count_q   <= '0;
      empty_count_q <= '0;
    end else begin
      if (pop && tlast) pkt_count_q <= pkt_count_q + 32'd1;
      if ((state_q == S_IDLE) && ready_for_forwarder && (len_sat == '0))
        empty_count_q <= empty_count_q + 32'd1;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign empty_count = empty_count_q;
`endif

endmodule

// File: tb/tb_axis_forwarder.sv
module tb_axis_forwarder;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int PW = 10;

  logic          axi_aclk = 1'b0;
  logic          resetn   = 1'b0;
  logic          ready    = 1'b0;
  logic [PW-1:0] len      = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic          done;

  axis_forwarder_if #(.DATA_WIDTH(DW)) m_axis ();
`ifdef FWD_PKT_COUNT_EN
  logic [31:0] pkt_count, empty_count;
`endif

  axis_forwarder #(.SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW)) dut (
    .axi_aclk            (axi_aclk),
    .resetn              (resetn),
    .ready_for_forwarder (ready),
    .len_to_forwarder    (len),
    .forwarder_rd_addr   (rd_addr),
    .forwarder_rd_en     (rd_en),
    .forwarder_rd_data   (rd_data),
    .forwarder_done      (done),
    .m_axis              (m_axis.master)
`ifdef FWD_PKT_COUNT_EN
    ,
    .pkt_count           (pkt_count),
    .empty_count         (empty_count)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  // Packet buffer with 1-cycle read latency.
  logic [DW-1:0] mem [0:511];
  always @(posedge axi_aclk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int exp_addr = 0, pkt_len_sat = 0, beats_pkt = 0;
  int n_done = 0, exp_done = 0, exp_pkts = 0, exp_empty = 0;
  int mode = 0;
  bit stalled = 0, in_pkt = 0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // tready pattern: 0 = always high, 1 = alternating, 2 = random
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge axi_aclk); #1;
      case (mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = ~m_axis.tready;
        default: m_axis.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t b;
    forever begin
      @(negedge axi_aclk);
      if (resetn) begin
        if (rd_en) begin
          chk("rd_addr", 64'(rd_addr), 64'(exp_addr % 512));
          chk("rd_in_range", 64'(exp_addr < pkt_len_sat), 64'd1);
          exp_addr++;
        end
        if (stalled) begin
          chk("tvalid_hold", 64'(m_axis.tvalid), 64'd1);
          chk("tdata_hold", m_axis.tdata, last_data);
        end
        if (mode == 0 && in_pkt) chk("no_bubble", 64'(m_axis.tvalid), 64'd1);
        if (m_axis.tvalid && exp_q.size() == 0) chk("tvalid_unexpected", 64'd1, 64'd0);
        if (m_axis.tvalid && m_axis.tready && exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("tdata", m_axis.tdata, b.d);
          chk("tlast", 64'(m_axis.tlast), 64'(b.l));
          beats_pkt++;
          in_pkt = !b.l;
        end
        if (rd_en || (m_axis.tvalid && m_axis.tready))
          chk("outstanding_le2", 64'((exp_addr - beats_pkt) <= 2), 64'd1);
        stalled   = m_axis.tvalid && !m_axis.tready;
        last_data = m_axis.tdata;
        if (done) begin
          n_done++;
          chk("done_after_last", 64'(exp_q.size()), 64'd0);
          chk("reads_issued", 64'(exp_addr), 64'(pkt_len_sat));
        end
      end
    end
  end

  task automatic run_pkt(input int l, input int md, input bit beef, input bit abort);
    int lsat, k, st;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    if (beef) mem[0] = 64'hDEADBEEF;
    lsat = (l > 512) ? 512 : l;
    mode = md; exp_addr = 0; beats_pkt = 0; in_pkt = 0; stalled = 0;
    pkt_len_sat = lsat;
    for (int i = 0; i < lsat; i++) begin
      beat_t b;
      b.d = mem[i];
      b.l = (i == lsat - 1);
      exp_q.push_back(b);
    end
    if (!abort) begin
      exp_done++;
      if (lsat > 0) exp_pkts++; else exp_empty++;
    end
    ready = 1'b1; len = PW'(l);
    @(posedge axi_aclk); #1;
    ready = 1'b0; len = PW'($urandom);   // later changes must be ignored
    if (lsat > 0) begin
      chk("lat_rd_en_c1", 64'(rd_en), 64'd1);
      chk("lat_tvalid_c1", 64'(m_axis.tvalid), 64'd0);
      @(posedge axi_aclk); #1;
      chk("lat_tvalid_c2", 64'(m_axis.tvalid), 64'd0);
      @(posedge axi_aclk); #1;
      chk("lat_tvalid_c3", 64'(m_axis.tvalid), 64'd1);
    end else begin
      chk("zero_no_rd", 64'(rd_en), 64'd0);
    end
    if (abort) begin
      k = 0;
      while (beats_pkt < 2 && k < 100) begin @(posedge axi_aclk); #1; k++; end
      chk("abort_reach_beat3", 64'(beats_pkt >= 2), 64'd1);
      resetn = 1'b0;
      #1;
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      exp_q.delete();
      pkt_len_sat = 0; exp_addr = 0; beats_pkt = 0; in_pkt = 0; stalled = 0;
      exp_pkts = 0; exp_empty = 0;
      @(posedge axi_aclk); @(posedge axi_aclk); #1;
      resetn = 1'b1;
      @(posedge axi_aclk); #1;
    end else begin
      st = n_done; k = 0;
      while (n_done == st && k < 4 * lsat + 50) begin @(posedge axi_aclk); k++; end
      chk("done_seen", 64'(n_done > st), 64'd1);
      repeat (3) @(posedge axi_aclk);
      #1;
    end
  endtask

  initial begin
    #12;
    chk("reset_rd_en", 64'(rd_en), 64'd0);
    chk("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("reset_tlast", 64'(m_axis.tlast), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_tdata", m_axis.tdata, 64'd0);
    chk("reset_rd_addr", 64'(rd_addr), 64'd0);
    @(posedge axi_aclk); #1;
    resetn = 1'b1;
    @(posedge axi_aclk); #1;

    run_pkt(4,   0, 1'b0, 1'b0);   // back-to-back beats
    run_pkt(5,   1, 1'b0, 1'b0);   // alternating tready
    run_pkt(0,   0, 1'b0, 1'b0);   // empty packet
    run_pkt(1,   0, 1'b1, 1'b0);   // single beat
    run_pkt(8,   0, 1'b0, 1'b1);   // reset mid-packet
    run_pkt(3,   0, 1'b0, 1'b0);   // clean restart at addr 0
    run_pkt(600, 0, 1'b0, 1'b0);   // saturated to 512
`ifdef FWD_PKT_COUNT_EN
    chk("pkt_count_after_600", 64'(pkt_count), 64'(exp_pkts));
`endif
    run_pkt(512, 2, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++)
      run_pkt(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24)),
              int'($urandom_range(0, 2)), 1'b0, 1'b0);
    run_pkt(1023, 2, 1'b0, 1'b0);

    chk("done_count", 64'(n_done), 64'(exp_done));
`ifdef FWD_PKT_COUNT_EN
    chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
    chk("empty_count", 64'(empty_count), 64'(exp_empty));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
